// File: rtl/playfield_writer_if.sv
// Lock handshake between the game-logic FSM (master) and the playfield writer (slave).
interface playfield_writer_if;
  logic        lock_valid;
  logic        lock_ready;
  logic [3:0]  piece_x;
  logic [4:0]  piece_y;
  logic [15:0] piece_mask;

  modport master (output lock_valid, piece_x, piece_y, piece_mask, input lock_ready);
  modport slave  (input lock_valid, piece_x, piece_y, piece_mask, output lock_ready);
endinterface

// File: rtl/playfield_writer.sv
// Tetris playfield store: merges locked pieces, collapses full rows bottom-up,
// reports lines cleared and exposes the board image to the color mapper.
module playfield_writer #(
  parameter int ROWS = 22,
  parameter int COLS = 12
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       clear_board,
  playfield_writer_if.slave          lk,
  output logic [ROWS-1:0][COLS-1:0]  row_contents,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 lines_cleared,
  output logic                       top_out
);

  localparam int PW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                     state_q;
  logic [ROWS-1:0][COLS-1:0]  board_q, merged_d;
  logic [PW-1:0]              ptr_q, dst_q;
  logic [2:0]                 count_q, lines_q;
  logic                       done_q, top_q;
  logic                       accept;
  logic [5:0]                 ry;
  logic [4:0]                 cx;

  assign lk.lock_ready  = (state_q == IDLE) & ~clear_board;
  assign accept         = lk.lock_valid & lk.lock_ready;
  assign row_contents   = board_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign lines_cleared  = lines_q;
  assign top_out        = top_q;

  // OR the 4x4 mask into the board; cells falling past the right or bottom edge are dropped, never wrapped.
  always_comb begin
    merged_d = board_q;
    ry       = '0;
    cx       = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ry = {1'b0, lk.piece_y} + 6'(r);
        cx = {1'b0, lk.piece_x} + 5'(c);
        if (lk.piece_mask[4*r+c] && (ry < 6'(ROWS)) && (cx < 5'(COLS)))
          merged_d[ry[PW-1:0]][cx[CW-1:0]] = 1'b1;
      end
    end
  end

  // Lock/scan/shift FSM; board, counters and status outputs are all registered here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      board_q <= '0;
      ptr_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      top_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      top_q  <= (|board_q[0]) | (|board_q[1]);
      if (clear_board) begin
        // Wipe wins over everything; lines_cleared deliberately keeps the last report.
        board_q <= '0;
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              board_q <= merged_d;
              ptr_q   <= PW'(ROWS - 1);
              count_q <= '0;
              state_q <= SCAN;
            end
          end
          SCAN: begin
            if (board_q[ptr_q] == {COLS{1'b1}}) begin
              dst_q   <= ptr_q;
              state_q <= SHIFT;
            end else if (ptr_q == '0) begin
              // done is high for exactly the single DONE cycle
              done_q  <= 1'b1;
              lines_q <= count_q;
              state_q <= DONE;
            end else begin
              ptr_q <= ptr_q - PW'(1);
            end
          end
          SHIFT: begin
            if (dst_q == '0) begin
              // ptr is left alone so the row that just dropped into it gets rechecked
              board_q[0] <= '0;
              count_q    <= count_q + 3'd1;
              state_q    <= SCAN;
            end else begin
              board_q[dst_q] <= board_q[dst_q - PW'(1)];
              dst_q          <= dst_q - PW'(1);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_playfield_writer.sv
// Bench for playfield_writer: reference board model feeds a scoreboard of
// expected (lines, latency, board, top_out) per lock, checked at the done pulse.
module tb_playfield_writer;

  typedef struct {
    logic [2:0]          lines;
    int                  lat;
    logic [21:0][11:0]   brd;
    logic                top;
  } exp_t;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               clear_board = 1'b0;
  logic [21:0][11:0]  row_contents;
  logic               busy, done, top_out;
  logic [2:0]         lines_cleared;

  playfield_writer_if pif();

  playfield_writer dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .clear_board   (clear_board),
    .lk            (pif.slave),
    .row_contents  (row_contents),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .top_out       (top_out)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [21:0][11:0] mdl;
  exp_t sbq[$];

  task automatic do_clear();
    @(negedge Clk);
    clear_board = 1'b1;
    @(negedge Clk);
    clear_board = 1'b0;
    mdl = '0;
  endtask

  // Present one lock, model its outcome into the scoreboard, then check it at done.
  task automatic do_lock(input int x, input int y, input logic [15:0] m, input string nm);
    exp_t e;
    int   lat;
    int   k;
    int   w;
    w = 0;
    @(negedge Clk);
    while (!pif.lock_ready && w < 100) begin
      @(negedge Clk);
      w++;
    end
    checks++;
    if (pif.lock_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got=%b want=1", nm, pif.lock_ready);
      return;
    end
    pif.lock_valid = 1'b1;
    pif.piece_x    = x[3:0];
    pif.piece_y    = y[4:0];
    pif.piece_mask = m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[4*r+c] && (y + r < 22) && (x + c < 12)) mdl[y+r][x+c] = 1'b1;
    e.lat   = 24;
    e.lines = 3'd0;
    k = 21;
    while (k >= 0) begin
      if (mdl[k] == 12'hFFF) begin
        for (int i = k; i > 0; i--) mdl[i] = mdl[i-1];
        mdl[0]  = '0;
        e.lines = e.lines + 3'd1;
        e.lat   = e.lat + k + 2;
      end else begin
        k--;
      end
    end
    e.brd = mdl;
    e.top = (|mdl[0]) | (|mdl[1]);
    sbq.push_back(e);
    lat = 1;
    do begin
      @(negedge Clk);
      pif.lock_valid = 1'b0;
      lat++;
    end while (done !== 1'b1 && lat < 400);
    e = sbq.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, lat, e.lat);
    end
    checks++;
    if (lines_cleared !== e.lines) begin
      failures++;
      $display("FAIL %s_lines got=%0d want=%0d", nm, lines_cleared, e.lines);
    end
    checks++;
    if (row_contents !== e.brd) begin
      failures++;
      $display("FAIL %s_board got=%h want=%h", nm, row_contents, e.brd);
    end
    checks++;
    if (top_out !== e.top) begin
      failures++;
      $display("FAIL %s_top got=%b want=%b", nm, top_out, e.top);
    end
    @(negedge Clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse got done=%b busy=%b want done=0 busy=0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (row_contents !== '0 || done !== 1'b0 || lines_cleared !== 3'd0 ||
        top_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rows=%h done=%b lines=%0d top=%b busy=%b want all zero",
               row_contents, done, lines_cleared, top_out, busy);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (pif.lock_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got ready=%b busy=%b want 1/0", pif.lock_ready, busy);
    end
    mdl = '0;
  endtask

  task automatic test_basic();
    do_clear();
    do_lock(0, 21, 16'h000F, "basic");
    checks++;
    if (row_contents[21] !== 12'h00F || lines_cleared !== 3'd0) begin
      failures++;
      $display("FAIL basic_row21 got=%h lines=%0d want=00f lines=0", row_contents[21], lines_cleared);
    end
  endtask

  task automatic test_single_clear();
    do_clear();
    do_lock(4, 21, 16'h000F, "pre1");
    do_lock(8, 21, 16'h000F, "pre2");
    do_lock(0, 20, 16'h000F, "pre3");
    do_lock(0, 21, 16'h000F, "clear1");
    checks++;
    if (row_contents[21] !== 12'h00F || row_contents[20] !== 12'h000 ||
        row_contents[0] !== 12'h000 || lines_cleared !== 3'd1) begin
      failures++;
      $display("FAIL clear1_rows got r21=%h r20=%h r0=%h lines=%0d want 00f/000/000 lines=1",
               row_contents[21], row_contents[20], row_contents[0], lines_cleared);
    end
  endtask

  task automatic test_four_lines();
    do_clear();
    do_lock(0, 18, 16'hEEEE, "pre4a");
    do_lock(4, 18, 16'hFFFF, "pre4b");
    do_lock(8, 18, 16'hFFFF, "pre4c");
    checks++;
    if (row_contents[18] !== 12'hFFE || row_contents[21] !== 12'hFFE) begin
      failures++;
      $display("FAIL pre4_rows got r18=%h r21=%h want ffe", row_contents[18], row_contents[21]);
    end
    do_lock(0, 18, 16'h1111, "tetris");
    checks++;
    if (row_contents !== '0 || lines_cleared !== 3'd4) begin
      failures++;
      $display("FAIL tetris_result got rows=%h lines=%0d want 0 lines=4", row_contents, lines_cleared);
    end
  endtask

  task automatic test_clear_in_shift();
    int w;
    do_clear();
    do_lock(4, 21, 16'h000F, "cs1");
    do_lock(8, 21, 16'h000F, "cs2");
    @(negedge Clk);
    pif.lock_valid = 1'b1;
    pif.piece_x    = 4'd0;
    pif.piece_y    = 5'd21;
    pif.piece_mask = 16'h000F;
    @(negedge Clk);
    pif.lock_valid = 1'b0;
    repeat (4) @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL cs_busy got=%b want=1", busy);
    end
    clear_board = 1'b1;
    @(negedge Clk);
    clear_board = 1'b0;
    mdl = '0;
    checks++;
    if (row_contents !== '0 || busy !== 1'b0 || done !== 1'b0 || lines_cleared !== 3'd0) begin
      failures++;
      $display("FAIL cs_wipe got rows=%h busy=%b done=%b lines=%0d want 0/0/0/0",
               row_contents, busy, done, lines_cleared);
    end
    w = 0;
    repeat (60) begin
      @(negedge Clk);
      if (done === 1'b1) w++;
    end
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL cs_no_done got pulses=%0d want=0", w);
    end
  endtask

  task automatic test_edges();
    do_clear();
    do_lock(10, 20, 16'h00FF, "edge");
    checks++;
    if (row_contents[20] !== 12'hC00 || row_contents[21] !== 12'hC00) begin
      failures++;
      $display("FAIL edge_rows got r20=%h r21=%h want c00", row_contents[20], row_contents[21]);
    end
    do_lock(0, 30, 16'hFFFF, "below");
    do_lock(0, 1, 16'h0001, "top");
    checks++;
    if (top_out !== 1'b1 || row_contents[1] !== 12'h001) begin
      failures++;
      $display("FAIL top_flag got top=%b r1=%h want 1/001", top_out, row_contents[1]);
    end
  endtask

  task automatic test_clear_with_lock();
    do_clear();
    do_lock(0, 21, 16'h000F, "cwl_pre");
    @(negedge Clk);
    clear_board    = 1'b1;
    pif.lock_valid = 1'b1;
    pif.piece_x    = 4'd0;
    pif.piece_y    = 5'd10;
    pif.piece_mask = 16'h000F;
    #1;
    checks++;
    if (pif.lock_ready !== 1'b0) begin
      failures++;
      $display("FAIL cwl_ready got=%b want=0", pif.lock_ready);
    end
    @(negedge Clk);
    clear_board    = 1'b0;
    pif.lock_valid = 1'b0;
    mdl = '0;
    checks++;
    if (row_contents !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cwl_wipe got rows=%h busy=%b want 0/0", row_contents, busy);
    end
  endtask

  task automatic test_async_reset();
    do_lock(0, 21, 16'h000F, "ar_pre");
    @(negedge Clk);
    pif.lock_valid = 1'b1;
    pif.piece_x    = 4'd0;
    pif.piece_y    = 5'd5;
    pif.piece_mask = 16'h000F;
    @(negedge Clk);
    pif.lock_valid = 1'b0;
    repeat (3) @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (row_contents !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got rows=%h busy=%b want 0/0", row_contents, busy);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    mdl = '0;
  endtask

  initial begin
    pif.lock_valid = 1'b0;
    pif.piece_x    = '0;
    pif.piece_y    = '0;
    pif.piece_mask = '0;
    mdl = '0;
    test_reset();
    test_basic();
    test_single_clear();
    test_four_lines();
    test_clear_in_shift();
    test_edges();
    test_clear_with_lock();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/playfield_writer.md
Name: playfield_writer

Overview:
- Owns the Tetris playfield storage and drives the row_contents[22] bitmap consumed by the color mapper.
- Accepts locked pieces through a valid/ready handshake and merges each piece's 4x4 cell mask into the board.
- Scans for full rows, collapses the board downward and reports the number of cleared lines.
- Sits between game-logic FSM (writer side) and the VGA color mapper (reader side).

Parameters:
- ROWS, 22, playfield rows; row 0 = top.
- COLS, 12, playfield columns; bit j of a row = column j (x = 20*j pixels).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- clear_board  in  1  synchronous board wipe (new game)
- lock_valid  in  1  piece lock request
- lock_ready  out  1  block can accept lock
- piece_x  in  4  column of mask's left edge (0..15)
- piece_y  in  5  row of mask's top edge (0..31)
- piece_mask  in  16  4x4 cells, bit r*4+c = mask row r, col c
- row_contents  out  [ROWS] x COLS  registered board image
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a lock's clear pass finishes
- lines_cleared  out  3  rows removed by last lock (0..4), valid when done=1, held until next done
- top_out  out  1  registered; high when row 0 or row 1 is non-zero

Behaviour:
- Reset (async, Reset_n=0): all rows 0, state IDLE, done=0, lines_cleared=0, top_out=0; lock_ready=1 once Reset_n releases.
- lock_ready = (state==IDLE) & ~clear_board, combinational.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE: on lock_valid & lock_ready edge, merge in that edge: for every set mask bit, board[piece_y+r][piece_x+c] |= 1. Drop cells with column > COLS-1 or row > ROWS-1 silently; no wrap. Set ptr=ROWS-1, count=0, go to SCAN.
- SCAN, one row per cycle:
  - board[ptr]==all ones: dst=ptr, go to SHIFT.
  - else if ptr==0: go to DONE.
  - else ptr-=1.
- SHIFT, one row per cycle: board[dst]=board[dst-1], dst-=1. On the cycle dst==0: board[0]=0, count+=1, return to SCAN at the same ptr (the row is rechecked because a full row may have dropped into it).
- DONE (1 cycle): done=1, lines_cleared=count, then IDLE.
- Latency, no full rows: accept edge + 22 SCAN cycles + 1 DONE cycle. Each cleared row at index k adds k+1 SHIFT cycles.
- row_contents changes only at clock edges; the mapper may see intermediate shift states (acceptable, one frame).
- clear_board has priority in every state: at the next edge all rows=0, state=IDLE, count=0, no done pulse. lines_cleared holds its value.
- clear_board and lock_valid in the same IDLE cycle: lock not accepted (lock_ready=0); the writer must re-present it.
- lock_valid while busy: ignored; the writer holds the request until lock_ready.
- Overlap with already-set cells: OR semantics, no error flag.
- top_out is updated every cycle from the registered board.
- Async reset mid-SCAN/SHIFT: board and state return to reset values immediately.

Test Plan:
- Reset then idle -> all row_contents = 12'h000, lock_ready=1, busy=0, top_out=0.
- Lock mask 16'h000F at x=0,y=21 -> row21=12'h00F. done pulses exactly 24 cycles after the accept edge, lines_cleared=0.
- Preload row21=12'hFF0 via locks, then lock mask 16'h000F at x=0,y=21 -> row21 full and cleared, rows shift down by one, row0=0. done with lines_cleared=1; total cycles = 1+22+22+1+1 (extra SCAN recheck).
- Rows 18..21 = 12'hFFE, lock vertical I (mask 16'h1111) at x=0,y=18 -> lines_cleared=4, board all zero.
- Lock at x=10,y=20 with mask 16'h00FF -> only columns 10,11 of rows 20,21 set (row=12'hC00), cells at columns 12,13 dropped, no wrap into column 0/1.
- clear_board asserted during SHIFT -> next edge board=0, state IDLE, no done. clear_board with lock_valid in IDLE -> lock_ready=0, board=0.
